// File: rtl/nf_pulse_shaper.sv
// Minimum-pulse-width output driver: NFOUT follows REQ_LVL but holds every level >= HOLD_CYC clocks.
// Optional macro NFO_SYNC_EN inserts a 2-flop synchronizer on REQ_LVL.
module nf_pulse_shaper #(
    parameter int unsigned HOLD_CYC = 40,
    parameter int unsigned CNT_W    = 8
) (
    input  logic CLK,
    input  logic RESETB,
    input  logic EN,
    input  logic REQ_LVL,
    output logic NFOUT,
    output logic BUSY,
    output logic PEND,
    output logic LOST
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYC - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             seen, seen_nx;
    logic             nfout_nx;
    logic             lost_nx;
    logic             req_s;
    logic             req_e;
    logic             diff;

`ifdef NFO_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], REQ_LVL};
        end
    end

    assign req_s = sync_q[1];
`else
    assign req_s = REQ_LVL;
`endif

    // With EN low the request mirrors the output, so no new transition can start.
    assign req_e = EN ? req_s : NFOUT;
    assign diff  = req_e ^ NFOUT;
    assign BUSY  = (state == HOLD);
    assign PEND  = BUSY & diff;

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state <= IDLE;
            cnt   <= '0;
            seen  <= 1'b0;
            NFOUT <= 1'b0;
            LOST  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            seen  <= seen_nx;
            NFOUT <= nfout_nx;
            LOST  <= lost_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        seen_nx  = seen;
        nfout_nx = NFOUT;
        lost_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (diff) begin
                    nfout_nx = ~NFOUT;
                    cnt_nx   = RELOAD;
                    seen_nx  = 1'b0;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                    if (diff) begin
                        seen_nx = 1'b1;
                    end
                end else if (diff) begin
                    // Expiry with a pending request: toggle again without an idle gap.
                    nfout_nx = ~NFOUT;
                    cnt_nx   = RELOAD;
                    seen_nx  = 1'b0;
                end else begin
                    lost_nx  = seen;
                    seen_nx  = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_nf_pulse_shaper.sv
// Directed self-checking bench for nf_pulse_shaper (HOLD_CYC = 40).
module tb_nf_pulse_shaper;

    localparam int unsigned HOLD = 40;
`ifdef NFO_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic resetb;
    logic en;
    logic req_lvl;
    logic nfout;
    logic busy;
    logic pend;
    logic lost;

    int n_checks = 0;
    int n_fail   = 0;

    nf_pulse_shaper #(
        .HOLD_CYC (HOLD),
        .CNT_W    (8)
    ) dut (
        .CLK     (clk),
        .RESETB  (resetb),
        .EN      (en),
        .REQ_LVL (req_lvl),
        .NFOUT   (nfout),
        .BUSY    (busy),
        .PEND    (pend),
        .LOST    (lost)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetb  = 1'b0;
        req_lvl = 1'b0;
        en      = 1'b1;
        repeat (2) tick();
        resetb = 1'b1;
    endtask

    task automatic test_reset();
        resetb  = 1'b0;
        req_lvl = 1'b1;
        en      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({nfout, busy, pend, lost} !== 4'b0000) begin
                $display("FAIL reset_hold cyc=%0d got {nfout,busy,pend,lost}=%b want 0000", i, {nfout, busy, pend, lost});
                n_fail++;
            end
        end
        resetb = 1'b1;
        for (int j = 1; j <= LAT; j++) begin
            tick();
            n_checks++;
            if (nfout !== (j == LAT)) begin
                $display("FAIL reset_release tick=%0d got nfout=%b want %b", j, nfout, (j == LAT));
                n_fail++;
            end
        end
        repeat (5) tick();
        #3 resetb = 1'b0;
        #1;
        n_checks++;
        if ({nfout, busy} !== 2'b00) begin
            $display("FAIL reset_async got {nfout,busy}=%b want 00", {nfout, busy});
            n_fail++;
        end
        tick();
        resetb = 1'b1;
    endtask

    task automatic test_long();
        int busy_cnt = 0;
        int lost_cnt = 0;
        do_reset();
        req_lvl = 1'b1;
        for (int j = 1; j <= 100; j++) begin
            tick();
            n_checks++;
            if (nfout !== (j >= LAT)) begin
                $display("FAIL long_nfout tick=%0d got %b want %b", j, nfout, (j >= LAT));
                n_fail++;
            end
            if (busy === 1'b1) busy_cnt++;
            if (lost === 1'b1) lost_cnt++;
        end
        n_checks++;
        if (busy_cnt != int'(HOLD)) begin
            $display("FAIL long_busy_len got %0d want %0d", busy_cnt, HOLD);
            n_fail++;
        end
        n_checks++;
        if (lost_cnt != 0) begin
            $display("FAIL long_lost got %0d want 0", lost_cnt);
            n_fail++;
        end
    endtask

    task automatic test_short();
        do_reset();
        req_lvl = 1'b1;
        for (int j = 1; j <= 100; j++) begin
            tick();
            n_checks++;
            if (nfout !== (j >= LAT && j < LAT + 40)) begin
                $display("FAIL short_nfout tick=%0d got %b want %b", j, nfout, (j >= LAT && j < LAT + 40));
                n_fail++;
            end
            n_checks++;
            if (busy !== (j >= LAT && j < LAT + 80)) begin
                $display("FAIL short_busy tick=%0d got %b want %b", j, busy, (j >= LAT && j < LAT + 80));
                n_fail++;
            end
            n_checks++;
            if (lost !== 1'b0) begin
                $display("FAIL short_lost tick=%0d got %b want 0", j, lost);
                n_fail++;
            end
            if (j == 5) req_lvl = 1'b0;
        end
    endtask

    task automatic test_swallow();
        int pend_cnt = 0;
        do_reset();
        req_lvl = 1'b1;
        repeat (LAT) tick();
        n_checks++;
        if (nfout !== 1'b1) begin
            $display("FAIL swallow_rise got %b want 1", nfout);
            n_fail++;
        end
        req_lvl = 1'b0;
        for (int j = 1; j <= 60; j++) begin
            tick();
            if (pend === 1'b1) pend_cnt++;
            n_checks++;
            if (nfout !== 1'b1) begin
                $display("FAIL swallow_nfout tick=%0d got %b want 1", j, nfout);
                n_fail++;
            end
            n_checks++;
            if (lost !== (j == 40)) begin
                $display("FAIL swallow_lost tick=%0d got %b want %b", j, lost, (j == 40));
                n_fail++;
            end
            n_checks++;
            if (busy !== (j < 40)) begin
                $display("FAIL swallow_busy tick=%0d got %b want %b", j, busy, (j < 40));
                n_fail++;
            end
            if (j == 3) req_lvl = 1'b1;
        end
        n_checks++;
        if (pend_cnt != 3) begin
            $display("FAIL swallow_pend_len got %0d want 3", pend_cnt);
            n_fail++;
        end
    endtask

    task automatic test_en_drop();
        do_reset();
        req_lvl = 1'b1;
        repeat (LAT) tick();
        req_lvl = 1'b0;
        for (int j = 1; j <= 50; j++) begin
            tick();
            n_checks++;
            if ({nfout, busy, lost} !== {1'b1, (j < 40), (j == 40)}) begin
                $display("FAIL en_drop tick=%0d got {nfout,busy,lost}=%b want %b", j, {nfout, busy, lost}, {1'b1, (j < 40), (j == 40)});
                n_fail++;
            end
            if (j == 3) en = 1'b0;
        end
        en = 1'b1;
    endtask

    task automatic test_enable();
        do_reset();
        en      = 1'b0;
        req_lvl = 1'b1;
        for (int j = 1; j <= 50; j++) begin
            tick();
            n_checks++;
            if ({nfout, busy} !== 2'b00) begin
                $display("FAIL enable_off tick=%0d got {nfout,busy}=%b want 00", j, {nfout, busy});
                n_fail++;
            end
        end
        en = 1'b1;
        tick();
        n_checks++;
        if (nfout !== 1'b1) begin
            $display("FAIL enable_on got nfout=%b want 1", nfout);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        int   toggles = 0;
        int   last_t  = -1;
        logic prev;
        do_reset();
        prev = nfout;
        for (int t = 1; t <= 200; t++) begin
            req_lvl = (((t - 1) / 40) % 2) == 0;
            tick();
            if (nfout !== prev) begin
                toggles++;
                if (last_t >= 0) begin
                    n_checks++;
                    if (t - last_t != int'(HOLD)) begin
                        $display("FAIL b2b_interval tick=%0d got %0d want %0d", t, t - last_t, HOLD);
                        n_fail++;
                    end
                end
                last_t = t;
                prev   = nfout;
            end
            if (t >= LAT) begin
                n_checks++;
                if ({busy, lost} !== 2'b10) begin
                    $display("FAIL b2b_busy tick=%0d got {busy,lost}=%b want 10", t, {busy, lost});
                    n_fail++;
                end
            end
        end
        n_checks++;
        if (toggles != 5) begin
            $display("FAIL b2b_toggles got %0d want 5", toggles);
            n_fail++;
        end
    endtask

    initial begin
        resetb  = 1'b0;
        en      = 1'b1;
        req_lvl = 1'b0;
        test_reset();
        test_long();
        test_short();
        test_swallow();
        test_en_drop();
        test_enable();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
